// File: rtl/fsm_launcher_pkg.sv
// fsm_launcher_pkg: shared types for the start/busy/done launcher.
// Reused by the requesting controller to decode response status.
package fsm_launcher_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_PROTO   = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/fsm_launcher.sv
// fsm_launcher: accepts a job request (valid/ready), pulses start_o to a
// worker req_count_i times, waits for each done_i, then returns a status.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_valid_i/req_ready_o       request handshake, req_count_i = runs
//   start_o, busy_i, done_i       worker handshake
//   resp_valid_o/resp_ready_i     response handshake
//   resp_status_o                 OK / TIMEOUT / PROTO
//   resp_done_cnt_o               runs completed before the response
//   active_o                      high whenever not IDLE
module fsm_launcher #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NJOBW          = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [NJOBW-1:0] req_count_i,
    output logic             start_o,
    input  logic             busy_i,
    input  logic             done_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [1:0]       resp_status_o,
    output logic [NJOBW-1:0] resp_done_cnt_o,
    output logic             active_o
);
    import fsm_launcher_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    status_e          r_status;
    status_e          w_status_nxt;
    logic [NJOBW-1:0] r_count;
    logic [NJOBW-1:0] w_count_nxt;
    logic [NJOBW-1:0] r_done_cnt;
    logic [NJOBW-1:0] w_done_cnt_nxt;
    logic [NJOBW-1:0] w_done_inc;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nxt;

    assign w_done_inc = r_done_cnt + NJOBW'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_status_nxt   = r_status;
        w_count_nxt    = r_count;
        w_done_cnt_nxt = r_done_cnt;
        w_timer_nxt    = r_timer;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_count_nxt    = req_count_i;
                    w_done_cnt_nxt = '0;
                    w_timer_nxt    = '0;
                    w_status_nxt   = ST_OK;
                    if (req_count_i == '0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                // done wins over both faults, so a done in the
                // final timer cycle still counts as success
                if (done_i) begin
                    w_done_cnt_nxt = w_done_inc;
                    if (w_done_inc == r_count) begin
                        w_state_nxt  = S_RESP;
                        w_status_nxt = ST_OK;
                    end else begin
                        w_state_nxt = S_START;
                    end
                end else if (!busy_i) begin
                    w_state_nxt  = S_RESP;
                    w_status_nxt = ST_PROTO;
                end else if (r_timer == TMAX) begin
                    w_state_nxt  = S_RESP;
                    w_status_nxt = ST_TIMEOUT;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_status_nxt   = ST_OK;
                w_count_nxt    = '0;
                w_done_cnt_nxt = '0;
                w_timer_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_status   <= ST_OK;
            r_count    <= '0;
            r_done_cnt <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_status   <= w_status_nxt;
            r_count    <= w_count_nxt;
            r_done_cnt <= w_done_cnt_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign start_o         = (r_state == S_START);
    assign resp_valid_o    = (r_state == S_RESP);
    assign active_o        = (r_state != S_IDLE);
    assign resp_status_o   = r_status;
    assign resp_done_cnt_o = r_done_cnt;

endmodule

// File: tb/tb_fsm_launcher.sv
// tb_fsm_launcher: directed table, hand sequences and random jobs
// checked against a run-cost model of the launcher.
module tb_fsm_launcher;
    import fsm_launcher_pkg::*;

    localparam int TO  = 16;
    localparam int TOB = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, start, busy, done;
    logic       resp_valid, resp_ready, active;
    logic [3:0] req_count, resp_cnt;
    logic [1:0] resp_status;

    logic       b_req_valid, b_req_ready, b_start, b_busy, b_done;
    logic       b_resp_valid, b_resp_ready, b_active;
    logic [3:0] b_req_count, b_resp_cnt;
    logic [1:0] b_resp_status;

    fsm_launcher #(.TIMEOUT_CYCLES(TO), .NJOBW(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_count_i(req_count), .start_o(start),
        .busy_i(busy), .done_i(done),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_status_o(resp_status), .resp_done_cnt_o(resp_cnt),
        .active_o(active)
    );

    fsm_launcher #(.TIMEOUT_CYCLES(TOB), .NJOBW(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_count_i(b_req_count), .start_o(b_start),
        .busy_i(b_busy), .done_i(b_done),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
        .resp_status_o(b_resp_status), .resp_done_cnt_o(b_resp_cnt),
        .active_o(b_active)
    );

    // w = busy WAIT cycles before done; p >= 0 drops busy at WAIT index p
    typedef struct {
        int w;
        int p;
    } run_t;

    typedef struct {
        int cnt;
        int w;
        int frun;
        int fkind;
        int fp;
        int rdly;
        int est;
        int ecnt;
        int elat;
        int es;
    } vec_t;

    run_t wq[$];
    run_t wk_cur;
    bit   wk_act;
    int   wk_j;
    int   n_starts;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic worker_step();
        if (start === 1'b1) begin
            n_starts++;
            if (wq.size() != 0) begin
                wk_cur = wq.pop_front();
                wk_act = 1'b1;
                wk_j   = 0;
                busy   = 1'b1;
                done   = 1'b0;
            end else begin
                wk_act = 1'b0;
                busy   = 1'b0;
                done   = 1'b0;
            end
        end else if (wk_act) begin
            wk_j++;
            if (wk_cur.p >= 0 && wk_j - 1 >= wk_cur.p) begin
                busy = 1'b0;
                done = 1'b0;
            end else if (wk_j <= wk_cur.w) begin
                busy = 1'b1;
                done = 1'b0;
            end else if (wk_j == wk_cur.w + 1) begin
                busy = 1'b1;
                done = 1'b1;
            end else begin
                busy   = 1'b0;
                done   = 1'b0;
                wk_act = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        worker_step();
    endtask

    task automatic run_txn(input string tag, input int cnt,
                           input int rdly, input int est,
                           input int ecnt, input int elat,
                           input int es);
        int lat;
        check({tag, " idle_ready"}, int'(req_ready), 1);
        req_valid  = 1'b1;
        req_count  = 4'(cnt);
        resp_ready = 1'b0;
        n_starts   = 0;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " status"}, int'(resp_status), est);
        check({tag, " done_cnt"}, int'(resp_cnt), ecnt);
        for (int i = 0; i < rdly; i++) begin
            tick();
            check({tag, " hold"},
                  int'({resp_valid, req_ready, resp_status, resp_cnt}),
                  int'({1'b1, 1'b0, 2'(est), 4'(ecnt)}));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " back_idle"},
              int'({req_ready, active, resp_valid}), 4);
        check({tag, " starts"}, n_starts, es);
        wq.delete();
    endtask

    vec_t vt[$];

    initial begin
        vec_t v;
        run_t r;
        int   lat, bs;
        rst = 1'b1;
        req_valid = 1'b0; req_count = '0; resp_ready = 1'b0;
        busy = 1'b0; done = 1'b0;
        b_req_valid = 1'b0; b_req_count = '0; b_resp_ready = 1'b0;
        b_busy = 1'b0; b_done = 1'b0;
        wk_act = 1'b0; wk_j = 0; n_starts = 0;
        wk_cur = '{w: 0, p: -1};

        vt.push_back('{3, 5, -1, 0, 0, 0, 0, 3, 22, 3});
        vt.push_back('{0, 5, -1, 0, 0, 1, 0, 0, 1, 0});
        vt.push_back('{1, 0, -1, 0, 0, 2, 0, 1, 3, 1});
        vt.push_back('{2, 5, 1, 2, 0, 0, 2, 1, 10, 2});
        vt.push_back('{1, 15, -1, 0, 0, 0, 0, 1, 18, 1});
        vt.push_back('{1, 5, 0, 1, 0, 0, 1, 0, 18, 1});
        vt.push_back('{2, 3, 1, 1, 0, 3, 1, 1, 23, 2});
        vt.push_back('{15, 0, -1, 0, 0, 0, 0, 15, 31, 15});
        vt.push_back('{1, 6, 0, 2, 4, 5, 2, 0, 7, 1});
        vt.push_back('{4, 1, -1, 0, 0, 5, 0, 4, 13, 4});

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_outputs",
              int'({req_ready, start, resp_valid, resp_status,
                    resp_cnt, active}),
              int'({1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0}));

        foreach (vt[k]) begin
            v = vt[k];
            for (int i = 0; i < v.cnt; i++) begin
                r = '{w: v.w, p: -1};
                if (i == v.frun && v.fkind == 1) r.w = 1000;
                if (i == v.frun && v.fkind == 2) r.p = v.fp;
                wq.push_back(r);
            end
            run_txn($sformatf("vec%0d", k), v.cnt, v.rdly,
                    v.est, v.ecnt, v.elat, v.es);
        end

        // reset in the middle of the second run's WAIT
        for (int i = 0; i < 3; i++) wq.push_back('{w: 5, p: -1});
        req_valid = 1'b1;
        req_count = 4'd3;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wq.delete();
        wk_act = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        check("mid_reset_outputs",
              int'({req_ready, start, resp_valid, resp_status,
                    resp_cnt, active}),
              int'({1'b1, 1'b0, 1'b0, 2'b00, 4'b0000, 1'b0}));
        for (int i = 0; i < 2; i++) wq.push_back('{w: 4, p: -1});
        run_txn("after_reset", 2, 0, 0, 2, 13, 2);

        // short-timeout instance, worker busy forever
        b_busy = 1'b1;
        b_req_valid = 1'b1;
        b_req_count = 4'd2;
        tick();
        b_req_valid = 1'b0;
        lat = 1;
        bs = (b_start === 1'b1) ? 1 : 0;
        while (b_resp_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
            if (b_start === 1'b1) bs++;
        end
        check("tmo4 latency", lat, 6);
        check("tmo4 status", int'(b_resp_status), 1);
        check("tmo4 done_cnt", int'(b_resp_cnt), 0);
        check("tmo4 starts", bs, 1);
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        b_busy = 1'b0;
        check("tmo4 back_idle", int'({b_req_ready, b_active}), 2);

        // random jobs against a run-cost model
        for (int t = 0; t < 40; t++) begin
            int cnt, elat, ecnt, est, es, rdly, kind;
            bit stop;
            cnt  = int'($urandom_range(0, 5));
            rdly = int'($urandom_range(0, 3));
            elat = 1;
            ecnt = 0;
            est  = 0;
            es   = 0;
            stop = 1'b0;
            for (int i = 0; i < cnt; i++) begin
                kind = int'($urandom_range(0, 9));
                if (kind < 7) begin
                    r = '{w: int'($urandom_range(0, TO - 1)), p: -1};
                end else if (kind == 7) begin
                    r = '{w: 1000, p: -1};
                end else begin
                    r.w = int'($urandom_range(1, TO + 3));
                    r.p = int'($urandom_range(0,
                          (r.w - 1 < TO - 1) ? r.w - 1 : TO - 1));
                end
                wq.push_back(r);
                if (!stop) begin
                    es++;
                    if (r.p >= 0) begin
                        elat += r.p + 2;
                        est = 2;
                        stop = 1'b1;
                    end else if (r.w >= TO) begin
                        elat += TO + 1;
                        est = 1;
                        stop = 1'b1;
                    end else begin
                        elat += r.w + 2;
                        ecnt++;
                    end
                end
            end
            run_txn($sformatf("rnd%0d", t), cnt, rdly,
                    est, ecnt, elat, es);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
